// File: rtl/address_unit.sv
`default_nettype none
// ============================================================================
// Module   : address_unit
// Purpose  : 16-bit program counter and address-bus multiplexer. After reset
//            it fetches the 6502 reset vector (low byte at RESET_VECTOR,
//            high byte at RESET_VECTOR+1) into the PC. It then raises ready
//            and selects the address source named by address_select.
// Options  : ADDRESS_UNIT_STACK_EN - address_select 3 drives the page-1 stack
//            address {8'h01, stack_pointer} instead of aliasing to the PC.
// Revision : 1.0 - initial release
// ============================================================================
module address_unit #(
  parameter logic [15:0] RESET_VECTOR = 16'hFFFC,
  parameter logic [7:0]  ZP_PAGE      = 8'h00
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clk_enable,
  input  logic        pc_enable,
  input  logic        pc_load,
  input  logic [15:0] pc_load_value,
  input  logic [1:0]  address_select,
  input  logic [15:0] memory_address,
  input  logic [7:0]  alu_result,
  input  logic [7:0]  stack_pointer,
  input  logic [7:0]  data_in,
  output logic [15:0] address,
  output logic [15:0] pc,
  output logic        ready,
  output logic        fetch
);

  // Address-source encodings driven by the decoder.
  localparam logic [1:0] SEL_PC    = 2'd0;
  localparam logic [1:0] SEL_MEM   = 2'd1;
  localparam logic [1:0] SEL_ZP    = 2'd2;
  localparam logic [1:0] SEL_STACK = 2'd3;

  // Vector high-byte address; wraps to $0000 if the vector sits at $FFFF.
  localparam logic [15:0] RESET_VECTOR_HI = RESET_VECTOR + 16'd1;

  typedef enum logic [1:0] {
    RV_LO = 2'd0,
    RV_HI = 2'd1,
    RUN   = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [7:0]  vector_lo;
  logic [15:0] pc_next;
  logic [15:0] run_address;
  logic        run_from_pc;

  // State register: reset restarts the vector sequence; clk_enable gates moves.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= RV_LO;
    end else if (clk_enable) begin
      state <= state_next;
    end
  end

  // Next-state logic: two vector-fetch cycles, then RUN until reset.
  always_comb begin
    state_next = state;
    case (state)
      RV_LO:   state_next = RV_HI;
      RV_HI:   state_next = RUN;
      RUN:     state_next = RUN;
      default: state_next = RV_LO;
    endcase
  end

  // Latch the vector low byte while the bus points at RESET_VECTOR.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vector_lo <= 8'h00;
    end else if (clk_enable && (state == RV_LO)) begin
      vector_lo <= data_in;
    end
  end

  // Next PC: vector load in RV_HI; in RUN, jump beats increment beats hold.
  always_comb begin
    pc_next = pc;
    case (state)
      RV_HI: pc_next = {data_in, vector_lo};
      RUN: begin
        if (pc_load) begin
          pc_next = pc_load_value;
        end else if (pc_enable) begin
          pc_next = pc + 16'd1;
        end
      end
      default: pc_next = pc;
    endcase
  end

  // Program counter register; holds completely while clk_enable is low.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc <= 16'h0000;
    end else if (clk_enable) begin
      pc <= pc_next;
    end
  end

  // RUN-state address source. The zero-page form never carries into the
  // high byte, so indexed zero-page accesses wrap within ZP_PAGE.
  always_comb begin
    run_address = pc;
    run_from_pc = 1'b1;
    case (address_select)
      SEL_PC: begin
        run_address = pc;
        run_from_pc = 1'b1;
      end
      SEL_MEM: begin
        run_address = memory_address;
        run_from_pc = 1'b0;
      end
      SEL_ZP: begin
        run_address = {ZP_PAGE, alu_result};
        run_from_pc = 1'b0;
      end
      SEL_STACK: begin
`ifdef ADDRESS_UNIT_STACK_EN
        run_address = {8'h01, stack_pointer};
        run_from_pc = 1'b0;
`else
        run_address = pc;
        run_from_pc = 1'b1;
`endif
      end
      default: begin
        run_address = pc;
        run_from_pc = 1'b1;
      end
    endcase
  end

`ifndef ADDRESS_UNIT_STACK_EN
  // Stack pointer has no consumer when the stack source is compiled out.
  logic _unused;
  assign _unused = &{1'b0, stack_pointer};
`endif

  // Output stage: vector addresses during the fetch, selected source in RUN.
  always_comb begin
    address = run_address;
    ready   = 1'b0;
    fetch   = 1'b0;
    case (state)
      RV_LO: address = RESET_VECTOR;
      RV_HI: address = RESET_VECTOR_HI;
      RUN: begin
        address = run_address;
        ready   = 1'b1;
        fetch   = run_from_pc;
      end
      default: address = RESET_VECTOR;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_address_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_address_unit
// Purpose  : Directed self-checking bench for address_unit: vector fetch,
//            increment/wrap, address mux, load priority, stall, mid-run
//            reset and the address_select 3 behaviour for either build.
// Revision : 1.0 - initial release
// ============================================================================
module tb_address_unit;

  logic        clk;
  logic        rst_n;
  logic        clk_enable;
  logic        pc_enable;
  logic        pc_load;
  logic [15:0] pc_load_value;
  logic [1:0]  address_select;
  logic [15:0] memory_address;
  logic [7:0]  alu_result;
  logic [7:0]  stack_pointer;
  logic [7:0]  data_in;
  logic [15:0] address;
  logic [15:0] pc;
  logic        ready;
  logic        fetch;

  int vectors;
  int miscompares;

  address_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .clk_enable     (clk_enable),
    .pc_enable      (pc_enable),
    .pc_load        (pc_load),
    .pc_load_value  (pc_load_value),
    .address_select (address_select),
    .memory_address (memory_address),
    .alu_result     (alu_result),
    .stack_pointer  (stack_pointer),
    .data_in        (data_in),
    .address        (address),
    .pc             (pc),
    .ready          (ready),
    .fetch          (fetch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock edge; inputs change and outputs are sampled 1 ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Jump the PC to a value from RUN, leaving pc_enable low.
  task automatic load_pc(input logic [15:0] value);
    pc_load       = 1'b1;
    pc_load_value = value;
    tick();
    pc_load       = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clk_enable = 1'b0;
    address_select = 2'd1;
    memory_address = 16'h5555;
    tick();
    tick();
    vectors++;
    if (pc !== 16'h0000) begin
      miscompares++;
      $display("FAIL reset_pc: got %h expected 0000", pc);
    end
    vectors++;
    if (ready !== 1'b0 || fetch !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_ready_fetch: got ready=%b fetch=%b expected 0 0", ready, fetch);
    end
    vectors++;
    if (address !== 16'hFFFC) begin
      miscompares++;
      $display("FAIL reset_address_ignores_sel: got %h expected fffc", address);
    end
    address_select = 2'd0;
  endtask

  task automatic test_vector_fetch();
    rst_n = 1'b1;
    clk_enable = 1'b0;
    tick();
    vectors++;
    if (address !== 16'hFFFC) begin
      miscompares++;
      $display("FAIL stall_in_rv_lo: got %h expected fffc", address);
    end
    clk_enable = 1'b1;
    data_in = 8'h34;
    pc_load = 1'b1;
    pc_load_value = 16'hBEEF;
    pc_enable = 1'b1;
    tick();
    vectors++;
    if (address !== 16'hFFFD || ready !== 1'b0) begin
      miscompares++;
      $display("FAIL rv_hi_address: got %h ready=%b expected fffd ready=0", address, ready);
    end
    data_in = 8'h12;
    tick();
    pc_load = 1'b0;
    pc_enable = 1'b0;
    vectors++;
    if (pc !== 16'h1234) begin
      miscompares++;
      $display("FAIL vector_pc: got %h expected 1234", pc);
    end
    vectors++;
    if (ready !== 1'b1 || fetch !== 1'b1 || address !== 16'h1234) begin
      miscompares++;
      $display("FAIL run_outputs: got ready=%b fetch=%b addr=%h expected 1 1 1234",
               ready, fetch, address);
    end
  endtask

  task automatic test_increment_wrap();
    load_pc(16'hFFFE);
    pc_enable = 1'b1;
    vectors++;
    if (address !== 16'hFFFE) begin
      miscompares++;
      $display("FAIL pre_inc_addr0: got %h expected fffe", address);
    end
    tick();
    vectors++;
    if (pc !== 16'hFFFF || address !== 16'hFFFF) begin
      miscompares++;
      $display("FAIL inc_ffff: got pc=%h addr=%h expected ffff ffff", pc, address);
    end
    tick();
    pc_enable = 1'b0;
    vectors++;
    if (pc !== 16'h0000) begin
      miscompares++;
      $display("FAIL wrap_0000: got %h expected 0000", pc);
    end
  endtask

  task automatic test_mux();
    load_pc(16'h0200);
    address_select = 2'd1;
    memory_address = 16'h00A5;
    #1;
    vectors++;
    if (address !== 16'h00A5 || fetch !== 1'b0) begin
      miscompares++;
      $display("FAIL mux_mem: got addr=%h fetch=%b expected 00a5 0", address, fetch);
    end
    address_select = 2'd2;
    alu_result = 8'hFF;
    #1;
    vectors++;
    if (address !== 16'h00FF || fetch !== 1'b0) begin
      miscompares++;
      $display("FAIL mux_zp: got addr=%h fetch=%b expected 00ff 0", address, fetch);
    end
    tick();
    vectors++;
    if (pc !== 16'h0200) begin
      miscompares++;
      $display("FAIL mux_pc_hold: got %h expected 0200", pc);
    end
    address_select = 2'd0;
    #1;
    vectors++;
    if (address !== 16'h0200) begin
      miscompares++;
      $display("FAIL mux_pc: got %h expected 0200", address);
    end
  endtask

  task automatic test_priority_stall();
    pc_load = 1'b1;
    pc_load_value = 16'hC000;
    pc_enable = 1'b1;
    tick();
    pc_load = 1'b0;
    vectors++;
    if (pc !== 16'hC000) begin
      miscompares++;
      $display("FAIL load_priority: got %h expected c000", pc);
    end
    clk_enable = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    vectors++;
    if (pc !== 16'hC000 || ready !== 1'b1) begin
      miscompares++;
      $display("FAIL stall_hold: got pc=%h ready=%b expected c000 1", pc, ready);
    end
    clk_enable = 1'b1;
    tick();
    pc_enable = 1'b0;
    vectors++;
    if (pc !== 16'hC001) begin
      miscompares++;
      $display("FAIL resume_inc: got %h expected c001", pc);
    end
  endtask

  task automatic test_reset_mid();
    load_pc(16'h1234);
    rst_n = 1'b0;
    tick();
    vectors++;
    if (pc !== 16'h0000 || ready !== 1'b0 || address !== 16'hFFFC) begin
      miscompares++;
      $display("FAIL mid_reset: got pc=%h ready=%b addr=%h expected 0000 0 fffc",
               pc, ready, address);
    end
    rst_n = 1'b1;
    data_in = 8'h78;
    tick();
    data_in = 8'h56;
    tick();
    vectors++;
    if (pc !== 16'h5678 || ready !== 1'b1) begin
      miscompares++;
      $display("FAIL refetch: got pc=%h ready=%b expected 5678 1", pc, ready);
    end
  endtask

  task automatic test_sel3();
    logic [15:0] exp_addr;
    logic        exp_fetch;
`ifdef ADDRESS_UNIT_STACK_EN
    exp_addr  = 16'h01FD;
    exp_fetch = 1'b0;
`else
    exp_addr  = 16'h5678;
    exp_fetch = 1'b1;
`endif
    address_select = 2'd3;
    stack_pointer = 8'hFD;
    #1;
    vectors++;
    if (address !== exp_addr || fetch !== exp_fetch) begin
      miscompares++;
      $display("FAIL sel3: got addr=%h fetch=%b expected %h %b",
               address, fetch, exp_addr, exp_fetch);
    end
    address_select = 2'd0;
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst_n = 1'b0;
    clk_enable = 1'b0;
    pc_enable = 1'b0;
    pc_load = 1'b0;
    pc_load_value = 16'h0000;
    address_select = 2'd0;
    memory_address = 16'h0000;
    alu_result = 8'h00;
    stack_pointer = 8'h00;
    data_in = 8'h00;

    test_reset();
    test_vector_fetch();
    test_increment_wrap();
    test_mux();
    test_priority_stall();
    test_reset_mid();
    test_sel3();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
